// File: rtl/ssp_reg_sync_rx.sv
// SSPCLK-domain receiver for the SSPCR0/SSPCPSR two-buffer synchronisation.
// Toggle triggers are synchronised, captured into shadows and applied while the core is idle.
module ssp_reg_sync_rx #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        SSPCLK,
    input  logic        SSPRST,
    input  logic [15:0] SSPCR0In,
    input  logic [6:0]  SSPCPSRIn,
    input  logic        CR0Update,
    input  logic        CPSRUpdate,
    input  logic [3:0]  SSPCR1In,
    input  logic        ApplyEn,
    output logic [15:0] SSPCR0Act,
    output logic [6:0]  SSPCPSRAct,
    output logic [3:0]  SSPCR1Sync,
    output logic        CR0Pend,
    output logic        CPSRPend,
    output logic        CR0Applied,
    output logic        CPSRApplied,
    output logic        CR0Ack,
    output logic        CPSRAck
);

    logic [SYNC_STAGES-1:0] cr0_sync_q, cpsr_sync_q;
    logic                   cr0_hist_q, cpsr_hist_q;
    logic [15:0]            cr0_shadow_q, cr0_shadow_d, cr0_act_q, cr0_act_d;
    logic [6:0]             cpsr_shadow_q, cpsr_shadow_d, cpsr_act_q, cpsr_act_d;
    logic                   cr0_pend_q, cr0_pend_d, cpsr_pend_q, cpsr_pend_d;
    logic                   cr0_applied_q, cpsr_applied_q;
    logic                   cr0_edge, cpsr_edge, cr0_apply, cpsr_apply;
    logic [3:0]             cr1_sync_q [SYNC_STAGES];

    always_comb begin
        cr0_edge      = cr0_sync_q[SYNC_STAGES-1] ^ cr0_hist_q;
        cpsr_edge     = cpsr_sync_q[SYNC_STAGES-1] ^ cpsr_hist_q;
        cr0_apply     = cr0_pend_q & ApplyEn;
        cpsr_apply    = cpsr_pend_q & ApplyEn;
        // An edge on the apply cycle: active takes the old shadow, shadow takes the new buffer.
        cr0_shadow_d  = cr0_edge ? SSPCR0In : cr0_shadow_q;
        cpsr_shadow_d = cpsr_edge ? SSPCPSRIn : cpsr_shadow_q;
        cr0_act_d     = cr0_apply ? cr0_shadow_q : cr0_act_q;
        cpsr_act_d    = cpsr_apply ? cpsr_shadow_q : cpsr_act_q;
        cr0_pend_d    = cr0_edge | (cr0_pend_q & ~cr0_apply);
        cpsr_pend_d   = cpsr_edge | (cpsr_pend_q & ~cpsr_apply);
    end

    always_ff @(posedge SSPCLK) begin
        if (SSPRST) begin
            cr0_sync_q     <= '0;
            cpsr_sync_q    <= '0;
            cr0_hist_q     <= 1'b0;
            cpsr_hist_q    <= 1'b0;
            cr0_shadow_q   <= '0;
            cpsr_shadow_q  <= '0;
            cr0_act_q      <= '0;
            cpsr_act_q     <= '0;
            cr0_pend_q     <= 1'b0;
            cpsr_pend_q    <= 1'b0;
            cr0_applied_q  <= 1'b0;
            cpsr_applied_q <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                cr1_sync_q[i] <= '0;
            end
        end else begin
            cr0_sync_q     <= {cr0_sync_q[SYNC_STAGES-2:0], CR0Update};
            cpsr_sync_q    <= {cpsr_sync_q[SYNC_STAGES-2:0], CPSRUpdate};
            cr0_hist_q     <= cr0_sync_q[SYNC_STAGES-1];
            cpsr_hist_q    <= cpsr_sync_q[SYNC_STAGES-1];
            cr0_shadow_q   <= cr0_shadow_d;
            cpsr_shadow_q  <= cpsr_shadow_d;
            cr0_act_q      <= cr0_act_d;
            cpsr_act_q     <= cpsr_act_d;
            cr0_pend_q     <= cr0_pend_d;
            cpsr_pend_q    <= cpsr_pend_d;
            cr0_applied_q  <= cr0_apply;
            cpsr_applied_q <= cpsr_apply;
            cr1_sync_q[0]  <= SSPCR1In;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                cr1_sync_q[i] <= cr1_sync_q[i-1];
            end
        end
    end

    assign SSPCR0Act   = cr0_act_q;
    assign SSPCPSRAct  = cpsr_act_q;
    assign SSPCR1Sync  = cr1_sync_q[SYNC_STAGES-1];
    assign CR0Pend     = cr0_pend_q;
    assign CPSRPend    = cpsr_pend_q;
    assign CR0Applied  = cr0_applied_q;
    assign CPSRApplied = cpsr_applied_q;
    assign CR0Ack      = cr0_hist_q;
    assign CPSRAck     = cpsr_hist_q;

endmodule

// File: doc/ssp_reg_sync_rx.md
Name: ssp_reg_sync_rx

Overview:
- SSPCLK-domain receiving end of the two-buffer register synchronisation for the SSP.
- Takes the PCLK-domain first-stage buffers (SSPCR0, SSPCPSR) and their toggle update triggers (CR0Update, CPSRUpdate). It detects each toggle after synchronisation, captures the buffer into a second-stage shadow, and applies the shadow to the active registers when the serial core is idle.
- Also double-synchronises the single-bit SSPCR1 fields and returns acknowledge toggles to the PCLK domain.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on each toggle and each CR1 bit (legal range 2..4).

Ports:
- SSPCLK  input  1  SSP serial clock; the only clock in this block.
- SSPRST  input  1  reset; synchronous to SSPCLK, active-high.
- SSPCR0In  input  16  first-stage SSPCR0 buffer (PCLK domain, quasi-static).
- SSPCPSRIn  input  7  first-stage SSPCPSR[7:1] buffer (PCLK domain, quasi-static).
- CR0Update  input  1  toggles once per SSPCR0 write (PCLK domain).
- CPSRUpdate  input  1  toggles once per SSPCPSR write (PCLK domain).
- SSPCR1In  input  4  SSPCR1[3:0] single-bit fields (LBM, SSE, MS, SOD), asynchronous.
- ApplyEn  input  1  serial core idle; shadow values may become active.
- SSPCR0Act  output  16  active SSPCR0 used by the serial core.
- SSPCPSRAct  output  7  active prescale divisor bits [7:1].
- SSPCR1Sync  output  4  synchronised SSPCR1[3:0].
- CR0Pend  output  1  a captured SSPCR0 is waiting for ApplyEn.
- CPSRPend  output  1  a captured SSPCPSR is waiting for ApplyEn.
- CR0Applied  output  1  one-cycle pulse when SSPCR0Act is loaded.
- CPSRApplied  output  1  one-cycle pulse when SSPCPSRAct is loaded.
- CR0Ack  output  1  synchronised copy of CR0Update, returned to the PCLK domain.
- CPSRAck  output  1  synchronised copy of CPSRUpdate, returned to the PCLK domain.

Behaviour:
- Reset (SSPRST=1 at an SSPCLK edge) sets all of the following to 0:
  - synchroniser and history flops, shadows, active registers;
  - CR0Pend, CPSRPend, CR0Applied, CPSRApplied, CR0Ack, CPSRAck, SSPCR1Sync.
  - Reset takes priority over every other event. A reset mid-update discards the pending value.
  - After reset the toggle history equals 0, matching the PCLK-side reset value of the trigger, so no spurious edge is detected.
- Toggle synchronisation, per trigger:
  - A SYNC_STAGES-flop chain produces TglSync; a history flop holds TglSync from the previous cycle.
  - Edge = TglSync XOR history.
  - Ack output = history flop.
- Capture: when Edge=1, the shadow loads the input buffer on the same SSPCLK edge that updates history, and Pend is set.
  - Buffer sampling is legal because the buffer has been stable for at least SYNC_STAGES cycles.
  - System constraint: software must not rewrite the same register until Ack matches the trigger. This block does not check the constraint.
- Latency with SYNC_STAGES=N, counted from the first SSPCLK edge that samples a flipped trigger as edge 1:
  - TglSync changes after edge N.
  - Shadow is loaded and Pend=1 after edge N+1.
  - Active register is loaded and the Applied pulse occurs at the earliest after edge N+2.
- Apply: on a cycle with Pend=1 and ApplyEn=1, the active register loads the shadow, Pend clears, and Applied=1 for exactly that next cycle.
- ApplyEn=0 holds Pend indefinitely. Active outputs never change except through the apply step.
- Simultaneous Edge and apply in one cycle:
  - The active register takes the old shadow.
  - The shadow takes the new buffer.
  - Pend stays 1 and Applied pulses.
- Second Edge while Pend=1 and ApplyEn=0: the shadow is overwritten and Pend stays 1. The intermediate value is never applied.
- CR0 and CPSR paths are fully independent and may apply in the same cycle.
- SSPCR1Sync: each bit passes through SYNC_STAGES flops, with no shadow and no ApplyEn gating.
- No combinational path from any input to any output. All outputs are registered.

Test Plan:
- Reset: SSPRST high for 2 cycles with inputs non-zero → all outputs 0; no Applied pulse after release.
- Basic CR0, ApplyEn=1, N=2: SSPCR0In=16'hC7A5, flip CR0Update → CR0Pend=1 after edge 3; SSPCR0Act=16'hC7A5 and CR0Applied=1 after edge 4; CR0Ack=1.
- Deferred apply: SSPCPSRIn=7'h12, toggle with ApplyEn=0 for 10 cycles → CPSRPend held at 1, SSPCPSRAct=0; raise ApplyEn → SSPCPSRAct=7'h12 next edge, single CPSRApplied pulse.
- Overwrite: two CR0 updates (16'h0007, then 16'h000F after CR0Ack matches) while ApplyEn=0 → apply yields 16'h000F only, one CR0Applied pulse.
- Simultaneous edge and apply: arrange the second Edge on the apply cycle → SSPCR0Act=first value, CR0Pend stays 1; next apply loads the second value.
- CR1 and reset mid-update: SSPCR1In=4'b1010 → SSPCR1Sync=4'b1010 after 2 edges. Assert SSPRST while CR0Pend=1 → pending value lost, SSPCR0Act=0.
